// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped cache store.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      EVICT  = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int LINES_DEF  = 16;

endpackage

// File: rtl/cache_line_array.sv
// Valid/dirty/tag/data storage: one combinational read port, one FSM write port
// and one refill port; an FSM write to the same line overrides a simultaneous refill.
module cache_line_array #(
   parameter int TAG_W  = 26,
   parameter int DATA_W = 32,
   parameter int LINES  = 16,
   localparam int IDX_W = $clog2(LINES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              fill_en,
   input  logic [IDX_W-1:0]  fill_idx,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [DATA_W-1:0] fill_data
);

   logic [LINES-1:0]  valid_q, valid_d;
   logic [LINES-1:0]  dirty_q, dirty_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [TAG_W-1:0]  tag_d  [LINES];
   logic [DATA_W-1:0] data_q [LINES];
   logic [DATA_W-1:0] data_d [LINES];

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (fill_en) begin
         valid_d[fill_idx] = 1'b1;
         dirty_d[fill_idx] = 1'b0;
         tag_d[fill_idx]   = fill_tag;
         data_d[fill_idx]  = fill_data;
      end
      // Applied last so the FSM write wins on an index collision.
      if (wr_en) begin
         valid_d[wr_idx] = 1'b1;
         dirty_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = wr_tag;
         data_d[wr_idx]  = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_dirty = dirty_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/cache_store.sv
// Direct-mapped write-back cache store with dirty-victim eviction handshake.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_store
   import cache_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LINES  = LINES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cache_en_read,
   input  logic              cache_en_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              fill_en,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              evict_ack,
   output logic              cache_done,
   output logic              cache_found,
   output logic              dirty_data,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] evict_addr,
   output logic [DATA_W-1:0] evict_data
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int IDX   = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX - 2;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              is_write_q, is_write_d;
   logic              cache_done_q, cache_done_d;
   logic              found_q, found_d;
   logic              dirty_data_q, dirty_data_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] evict_addr_q, evict_addr_d;
   logic [DATA_W-1:0] evict_data_q, evict_data_d;

   logic [IDX-1:0]    idx;
   logic [TAG_W-1:0]  tag;
   logic              rd_valid, rd_dirty;
   logic [TAG_W-1:0]  rd_tag;
   logic [DATA_W-1:0] rd_data;
   logic              hit, victim_dirty, wr_en;
   logic              addr_lsb_unused;

   assign idx             = addr_q[IDX+1:2];
   assign tag             = addr_q[ADDR_W-1:IDX+2];
   assign hit             = rd_valid && (rd_tag == tag);
   assign victim_dirty    = rd_valid && rd_dirty && (rd_tag != tag);
   assign addr_lsb_unused = ^{addr[1:0], addr_q[1:0]};

   cache_line_array #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W),
      .LINES  (LINES)
   ) u_lines (
      .clk       (clk),
      .reset     (reset),
      .rd_idx    (idx),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_idx    (idx),
      .wr_tag    (tag),
      .wr_data   (wdata_q),
      .fill_en   (fill_en),
      .fill_idx  (addr[IDX+1:2]),
      .fill_tag  (addr[ADDR_W-1:IDX+2]),
      .fill_data (fill_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         is_write_q   <= 1'b0;
         cache_done_q <= 1'b0;
         found_q      <= 1'b0;
         dirty_data_q <= 1'b0;
         rdata_q      <= '0;
         evict_addr_q <= '0;
         evict_data_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         is_write_q   <= is_write_d;
         cache_done_q <= cache_done_d;
         found_q      <= found_d;
         dirty_data_q <= dirty_data_d;
         rdata_q      <= rdata_d;
         evict_addr_q <= evict_addr_d;
         evict_data_q <= evict_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cache_en_read || cache_en_write) state_d = LOOKUP;
         LOOKUP:  state_d = (is_write_q && victim_dirty) ? EVICT : DONE;
         EVICT:   if (evict_ack) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      is_write_d   = is_write_q;
      cache_done_d = 1'b0;
      found_d      = found_q;
      dirty_data_d = 1'b0;
      rdata_d      = rdata_q;
      evict_addr_d = evict_addr_q;
      evict_data_d = evict_data_q;
      wr_en        = 1'b0;
      case (state_q)
         IDLE: begin
            if (cache_en_read || cache_en_write) begin
               addr_d     = addr;
               wdata_d    = wdata;
               is_write_d = !cache_en_read;
            end
         end
         LOOKUP: begin
            if (!is_write_q) begin
               cache_done_d = 1'b1;
               found_d      = hit;
               rdata_d      = rd_data;
            end else if (victim_dirty) begin
               dirty_data_d = 1'b1;
               evict_addr_d = {rd_tag, idx, 2'b00};
               evict_data_d = rd_data;
            end else begin
               wr_en        = 1'b1;
               cache_done_d = 1'b1;
               found_d      = hit;
            end
         end
         EVICT: begin
            if (evict_ack) begin
               wr_en        = 1'b1;
               cache_done_d = 1'b1;
               found_d      = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign cache_done  = cache_done_q;
   assign cache_found = found_q;
   assign dirty_data  = dirty_data_q;
   assign rdata       = rdata_q;
   assign evict_addr  = evict_addr_q;
   assign evict_data  = evict_data_q;

`ifdef CACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (cache_done_q && found_q && hit_count_q != 32'hFFFF_FFFF)
         hit_count_d = hit_count_q + 32'd1;
      if (cache_done_q && !found_q && miss_count_q != 32'hFFFF_FFFF)
         miss_count_d = miss_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_store.sv
// Directed bench for cache_store: stimulus pushes expected completions and evictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cache_store;

   logic        clk = 1'b0;
   logic        reset;
   logic        cache_en_read, cache_en_write;
   logic [31:0] addr, wdata;
   logic        fill_en;
   logic [31:0] fill_data;
   logic        evict_ack;
   logic        cache_done, cache_found, dirty_data;
   logic [31:0] rdata, evict_addr, evict_data;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        found;
      logic        chk_data;
      logic [31:0] data;
   } done_exp_t;

   typedef struct {
      logic [31:0] ev_addr;
      logic [31:0] ev_data;
   } evict_exp_t;

   done_exp_t  done_q[$];
   evict_exp_t evict_q[$];

   always #5 clk = ~clk;

   cache_store dut (
      .clk            (clk),
      .reset          (reset),
      .cache_en_read  (cache_en_read),
      .cache_en_write (cache_en_write),
      .addr           (addr),
      .wdata          (wdata),
      .fill_en        (fill_en),
      .fill_data      (fill_data),
      .evict_ack      (evict_ack),
      .cache_done     (cache_done),
      .cache_found    (cache_found),
      .dirty_data     (dirty_data),
      .rdata          (rdata),
      .evict_addr     (evict_addr),
      .evict_data     (evict_data)
`ifdef CACHE_STATS_EN
      ,
      .hit_count      (hit_count),
      .miss_count     (miss_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_done(input logic found, input logic chk_data, input logic [31:0] data);
      done_exp_t e;
      e.found = found; e.chk_data = chk_data; e.data = data;
      done_q.push_back(e);
   endtask

   task automatic expect_evict(input logic [31:0] a, input logic [31:0] d);
      evict_exp_t e;
      e.ev_addr = a; e.ev_data = d;
      evict_q.push_back(e);
   endtask

   // Monitor: compare every completion and dirty-victim pulse against the queues.
   always @(negedge clk) begin
      if (reset === 1'b0 && cache_done === 1'b1) begin
         if (done_q.size() == 0) begin
            chk("unexpected_cache_done", 32'd1, 32'd0);
         end else begin
            done_exp_t e;
            e = done_q.pop_front();
            chk("cache_found", {31'd0, cache_found}, {31'd0, e.found});
            if (e.chk_data) chk("rdata", rdata, e.data);
         end
      end
      if (reset === 1'b0 && dirty_data === 1'b1) begin
         if (evict_q.size() == 0) begin
            chk("unexpected_dirty_data", 32'd1, 32'd0);
         end else begin
            evict_exp_t v;
            v = evict_q.pop_front();
            chk("evict_addr", evict_addr, v.ev_addr);
            chk("evict_data", evict_data, v.ev_data);
         end
      end
   end

   task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input int exp_lat);
      int n;
      @(posedge clk); #1;
      cache_en_read = rd; cache_en_write = wr; addr = a; wdata = d;
      @(posedge clk); #1;
      cache_en_read = 1'b0; cache_en_write = 1'b0;
      n = 1;
      while (cache_done !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_latency", n, exp_lat);
   endtask

   task automatic fill(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      fill_en = 1'b1; addr = a; fill_data = d;
      @(posedge clk); #1;
      fill_en = 1'b0;
   endtask

   // Issue a write expected to hit a dirty victim; returns at the dirty_data cycle.
   task automatic dirty_write(input logic [31:0] a, input logic [31:0] d);
      int n;
      @(posedge clk); #1;
      cache_en_write = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      cache_en_write = 1'b0;
      n = 1;
      while (dirty_data !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("dirty_latency", n, 2);
   endtask

   initial begin
      int done_seen;
      reset = 1'b1;
      cache_en_read = 1'b0; cache_en_write = 1'b0;
      addr = '0; wdata = '0; fill_en = 1'b0; fill_data = '0; evict_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cache_done", {31'd0, cache_done}, 32'd0);
      chk("reset_cache_found", {31'd0, cache_found}, 32'd0);
      chk("reset_dirty_data", {31'd0, dirty_data}, 32'd0);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_evict_addr", evict_addr, 32'd0);
      chk("reset_evict_data", evict_data, 32'd0);
      reset = 1'b0;

      // Cold read miss, then refill and hit.
      expect_done(1'b0, 1'b0, 32'd0);
      req(1'b1, 1'b0, 32'h40, 32'd0, 2);
      fill(32'h40, 32'hA5A5_A5A5);
      expect_done(1'b1, 1'b1, 32'hA5A5_A5A5);
      req(1'b1, 1'b0, 32'h40, 32'd0, 2);

      // Clean write miss, then read back.
      expect_done(1'b0, 1'b0, 32'd0);
      req(1'b0, 1'b1, 32'h44, 32'h11, 2);
      expect_done(1'b1, 1'b1, 32'h11);
      req(1'b1, 1'b0, 32'h44, 32'd0, 2);

      // Refill colliding with an FSM write on the same line: the write wins.
      expect_done(1'b0, 1'b0, 32'd0);
      @(posedge clk); #1;
      cache_en_write = 1'b1; addr = 32'h4C; wdata = 32'h77;
      @(posedge clk); #1;
      cache_en_write = 1'b0; fill_en = 1'b1; fill_data = 32'hFFFF_0000;
      @(posedge clk); #1;
      fill_en = 1'b0;
      chk("collision_done", {31'd0, cache_done}, 32'd1);
      expect_done(1'b1, 1'b1, 32'h77);
      req(1'b1, 1'b0, 32'h4C, 32'd0, 2);

      // Dirty victim: line 1 holds 0x44, write 0x84, ack three cycles later.
      expect_evict(32'h44, 32'h11);
      expect_done(1'b0, 1'b0, 32'd0);
      dirty_write(32'h84, 32'h22);
      repeat (3) begin @(posedge clk); #1; end
      chk("evict_addr_held", evict_addr, 32'h44);
      chk("done_before_ack", {31'd0, cache_done}, 32'd0);
      evict_ack = 1'b1;
      @(posedge clk); #1;
      evict_ack = 1'b0;
      chk("done_after_ack", {31'd0, cache_done}, 32'd1);
      expect_done(1'b1, 1'b1, 32'h22);
      req(1'b1, 1'b0, 32'h84, 32'd0, 2);

`ifdef CACHE_STATS_EN
      @(posedge clk); #1;
      chk("hit_count_pre", hit_count, 32'd4);
      chk("miss_count_pre", miss_count, 32'd4);
`endif

      // Stray ack in IDLE must not disturb anything.
      @(posedge clk); #1; evict_ack = 1'b1;
      @(posedge clk); #1; evict_ack = 1'b0;

      // Reset during EVICT aborts: no completion, line not written.
      expect_evict(32'h84, 32'h22);
      dirty_write(32'h44, 32'h55);
      @(posedge clk); #1;
      reset = 1'b1;
      evict_ack = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      evict_ack = 1'b0;
      chk("abort_dirty_data", {31'd0, dirty_data}, 32'd0);
      chk("abort_evict_addr", evict_addr, 32'd0);
`ifdef CACHE_STATS_EN
      chk("hit_count_reset", hit_count, 32'd0);
      chk("miss_count_reset", miss_count, 32'd0);
`endif
      done_seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (cache_done === 1'b1) done_seen++;
      end
      chk("abort_no_done", done_seen, 0);
      expect_done(1'b0, 1'b0, 32'd0);
      req(1'b1, 1'b0, 32'h84, 32'd0, 2);

      // Read and write together: read wins, line unchanged.
      fill(32'h48, 32'h1234_5678);
      expect_done(1'b1, 1'b1, 32'h1234_5678);
      req(1'b1, 1'b1, 32'h48, 32'h99, 2);
      expect_done(1'b1, 1'b1, 32'h1234_5678);
      req(1'b1, 1'b0, 32'h48, 32'd0, 2);

      @(posedge clk); #1;
`ifdef CACHE_STATS_EN
      chk("hit_count_end", hit_count, 32'd2);
      chk("miss_count_end", miss_count, 32'd1);
`endif
      chk("pending_done", done_q.size(), 0);
      chk("pending_evict", evict_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
